fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 4, number of entries; a power of two, at least 2.
- AW, 32, width of the PC and instruction fields.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, the single clock; all state updates on its rising edge.
- rst_b, input, 1, asynchronous active-low reset.
- PC, input, AW, fetch address produced by the program counter.
- imem_instr, input, AW, instruction word read from instruction memory at PC.
- in_valid, input, 1, PC/imem_instr pair is valid this cycle.
- in_ready, output, 1, buffer accepts a pair this cycle; also the stall signal back to the program counter.
- flush, input, 1, discard all buffered entries (branch/jump redirect).
- out_valid, output, 1, head entry is valid.
- out_ready, input, 1, decode consumes the head entry this cycle.
- out_pc, output, AW, PC of the head entry.
- out_pc_plus4, output, AW, out_pc + 4.
- out_instr, output, AW, instruction of the head entry.
- count, output, ceil(log2(DEPTH+1)), number of occupied entries (3 bits at DEPTH=4).

Function
REQ-003 The block SHALL be a circular FIFO of DEPTH entries, each holding a {PC, imem_instr} pair, with read pointer, write pointer and occupancy count.
REQ-004 The write handshake SHALL complete when in_valid and in_ready are both high at a rising edge; the pair is then stored at the write pointer and the write pointer advances by 1.
REQ-005 The read handshake SHALL complete when out_valid and out_ready are both high at a rising edge; the read pointer then advances by 1.
REQ-006 in_ready SHALL equal (count != DEPTH); there is no write-when-full, even if a read occurs in the same cycle.
REQ-007 out_valid SHALL equal (count != 0).
REQ-008 out_pc, out_instr and out_pc_plus4 SHALL be driven combinationally from the entry at the read pointer.
REQ-009 Latency SHALL be one cycle: a pair written at edge N is presented on the outputs immediately after edge N when the buffer was empty; there is no same-cycle bypass from input to output.
REQ-010 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-011 out_pc_plus4 SHALL be computed modulo 2^AW; 0xFFFFFFFC + 4 = 0x00000000.
REQ-012 count SHALL update as follows:
- write only: +1.
- read only: -1.
- write and read in the same edge: unchanged, and both pointers advance.
- neither: unchanged.
REQ-013 flush SHALL be sampled synchronously. When flush is high at an edge, count and both pointers go to 0 and any write or read handshake in that cycle is ignored; flush has priority over both.
REQ-014 A read or write attempt that would violate REQ-006 or REQ-007 SHALL leave the state unchanged (no overflow, no underflow).
REQ-015 out_pc, out_instr and out_pc_plus4 SHALL be don't-care when out_valid is 0; the bench SHALL NOT check them in that case.

Reset
REQ-016 While rst_b is low, independent of clk:
- count = 0, both pointers = 0, out_valid = 0, in_ready = 1.
- Storage contents need not be cleared.
REQ-017 Assertion of rst_b mid-operation SHALL discard all entries immediately; after release, the first accepted pair SHALL appear at the head.
REQ-018 Release of rst_b SHALL take effect at the next rising clk edge; no handshake completes on an edge at which rst_b is low.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset: drive rst_b=0 for 2 cycles -> count=0, out_valid=0, in_ready=1; after release with no stimulus, state is unchanged.
- Fill/drain: write PC=0,4,8,12 with instr 0xA0..0xA3 and out_ready=0 -> count=4, in_ready=0; a fifth write is ignored; then out_ready=1 for 4 cycles -> outputs 0/0xA0 ... 12/0xA3 in order, out_pc_plus4 = out_pc+4, count ends at 0.
- Simultaneous read/write at count=2 -> count stays 2, head advances, and the new pair is read out after the older ones.
- Flush with in_valid=1 and out_ready=1 in the same cycle at count=3 -> count=0 next cycle, and the incoming pair is not stored.
- Wrap: 10 successive write+read pairs -> pointers wrap and data order is preserved; PC=0xFFFFFFFC gives out_pc_plus4=0x00000000.
- Async reset mid-fill (count=2, rst_b pulsed low between edges) -> out_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular FIFO between the program counter / instruction memory
// and decode. Each entry holds a {PC, instruction} pair. The head entry is
// presented combinationally; in_ready doubles as the PC stall signal.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [AW-1:0]                PC,
  input  logic [AW-1:0]                imem_instr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AW-1:0]                out_pc,
  output logic [AW-1:0]                out_pc_plus4,
  output logic [AW-1:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Pointer increment with explicit wrap from the last slot back to slot 0.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PTR_LAST) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1'b1);
    end
    return n;
  endfunction

  logic [AW-1:0] pc_mem    [DEPTH];
  logic [AW-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [PW-1:0] rd_ptr_s;
  logic [PW-1:0] wr_ptr_s;
  logic [CW-1:0] count_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          wr_fire_s;
  logic          rd_fire_s;
  logic          wr_en_s;

  // Handshake qualification; flush wins over both directions.
  always_comb begin
    wr_fire_s = in_valid & in_ready_r;
    rd_fire_s = out_valid_r & out_ready;
    wr_en_s   = wr_fire_s & ~flush & rst_b;
  end

  // Next pointer / occupancy computation; ready/valid flags follow the new count.
  always_comb begin
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    count_s  = count_r;
    if (flush) begin
      rd_ptr_s = {PW{1'b0}};
      wr_ptr_s = {PW{1'b0}};
      count_s  = {CW{1'b0}};
    end else begin
      if (wr_fire_s) begin
        wr_ptr_s = next_ptr(wr_ptr_r);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (rd_fire_s) begin
        rd_ptr_s = next_ptr(rd_ptr_r);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_s = count_r + CW'(1'b1);
        2'b01:   count_s = count_r - CW'(1'b1);
        default: count_s = count_r;
      endcase
    end
    in_ready_s  = (count_s != CNT_FULL);
    out_valid_s = (count_s != {CW{1'b0}});
  end

  // Control state register; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_ptr_s;
      wr_ptr_r    <= wr_ptr_s;
      count_r     <= count_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Entry storage; contents are not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      pc_mem[wr_ptr_r]    <= PC;
      instr_mem[wr_ptr_r] <= imem_instr;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign count        = count_r;
  assign out_pc       = pc_mem[rd_ptr_r];
  assign out_instr    = instr_mem[rd_ptr_r];
  assign out_pc_plus4 = pc_mem[rd_ptr_r] + AW'(3'd4);

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: directed scenarios followed by random traffic,
// checked by a queue-based scoreboard and an independent monitor.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [AW-1:0] PC = 32'd0;
  logic [AW-1:0] imem_instr = 32'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_plus4;
  logic [AW-1:0] out_instr;
  logic [2:0]    count;

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO of expected pairs plus an occupancy counter.
  logic [63:0] exp_q[$];
  int          m_count = 0;

  fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_b(rst_b), .PC(PC), .imem_instr(imem_instr),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update: reset/flush empty it, accepted writes push the pair.
  always @(posedge clk or negedge rst_b) begin
    int wr;
    int rd;
    if (!rst_b) begin
      exp_q.delete();
      m_count = 0;
    end else if (flush) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      wr = (in_valid && m_count != DEPTH) ? 1 : 0;
      rd = (out_ready && m_count != 0) ? 1 : 0;
      if (wr == 1) exp_q.push_back({PC, imem_instr});
      m_count = m_count + wr - rd;
    end
  end

  // Monitor: mid-cycle status checks, head comparison, pop on read handshake.
  always @(negedge clk) begin
    logic [31:0] hpc;
    logic [31:0] hins;
    logic [31:0] hp4;
    chk("count", {61'd0, count}, 64'(m_count));
    chk("in_ready", {63'd0, in_ready}, {63'd0, (m_count != DEPTH)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, (m_count != 0)});
    if (m_count != 0) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 64'd0, 64'd1);
      end else begin
        hpc  = exp_q[0][63:32];
        hins = exp_q[0][31:0];
        hp4  = hpc + 32'd4;
        chk("out_pc", {32'd0, out_pc}, {32'd0, hpc});
        chk("out_instr", {32'd0, out_instr}, {32'd0, hins});
        chk("out_pc_plus4", {32'd0, out_pc_plus4}, {32'd0, hp4});
        if (out_ready && !flush && rst_b) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid   = v;
    PC         = pc;
    imem_instr = ins;
    out_ready  = ordy;
    flush      = fl;
  endtask

  initial begin
    // Reset held for two cycles, then idle after release.
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("reset_count", {61'd0, count}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    rst_b = 1'b1;
    repeat (3) tick();

    // Fill to full, attempt a fifth write, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'd16, 32'hA4, 1'b0, 1'b0);
    tick();
    chk("full_count", {61'd0, count}, 64'd4);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (4) tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("drained_count", {61'd0, count}, 64'd0);

    // Simultaneous read and write at count 2.
    drive(1'b1, 32'h200, 32'hB0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h204, 32'hB1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h208, 32'hB2, 1'b1, 1'b0); tick();
    chk("rw_count", {61'd0, count}, 64'd2);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) tick();

    // Flush with concurrent write and read at count 3.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h30C, 32'hC3, 1'b1, 1'b1);
    tick();
    chk("flush_count", {61'd0, count}, 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (2) tick();

    // Wrap: one write, ten write+read pairs, including the top-of-space PC.
    drive(1'b1, 32'h400, 32'hD0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, (k == 5) ? 32'hFFFF_FFFC : 32'h404 + 32'(4 * k), 32'hD1 + 32'(k), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (2) tick();

    // Async reset mid-fill at count 2.
    drive(1'b1, 32'h500, 32'hE0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h504, 32'hE1, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_count", {61'd0, count}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    rst_b = 1'b1;
    drive(1'b1, 32'h600, 32'hF0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); repeat (2) tick();

    // Random traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
            $urandom,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (6) tick();
    chk("final_count", {61'd0, count}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
